// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the single-precision multiply path.
//   state_e    : sequencing states of fpu_mul_seq
//   op_class_e : operand classification produced by fpu_operand_classify
//   EXP_BIAS, EXP_MAX, NAN_MANT, MUL_ITERS : binary32 format constants
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    FINITE = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } op_class_e;

  localparam int          EXP_BIAS  = 127;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [22:0] NAN_MANT  = 23'h1;
  localparam int          MUL_ITERS = 24;

endpackage

// File: rtl/fpu_operand_classify.sv
// fpu_operand_classify: combinational binary32 operand classifier.
//   op       in  32  binary32 operand
//   op_class out  2  ZERO / FINITE / INF / NAN
//   mant     out 24  mantissa with the hidden bit restored
// Subnormals are reported as ZERO (flush-to-zero).
module fpu_operand_classify
  import fpu_pkg::*;
(
  input  logic [31:0] op,
  output op_class_e   op_class,
  output logic [23:0] mant
);

  always_comb begin
    mant = {1'b1, op[22:0]};
    if (op[30:23] == 8'h00) begin
      op_class = ZERO;
    end else if (op[30:23] == EXP_MAX) begin
      op_class = (op[22:0] == 23'd0) ? INF : NAN;
    end else begin
      op_class = FINITE;
    end
  end

endmodule

// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: sequencing controller for the binary32 multiply path.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b sampled on accept)
//   out_valid/out_ready result handshake (result held until accepted)
//   result              product, stable while out_valid
//   busy                high whenever the FSM is not in IDLE
//   flags               {NV, OF, UF, NX}; exists only with FPU_MUL_FLAGS_EN
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and data steady until that edge.
// state_q is the observable FSM state for checkers.
module fpu_mul_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
`ifdef FPU_MUL_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d;
  logic signed [9:0]  e_q, e_d;
  logic [47:0]        prod_q, prod_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [22:0]        man_q, man_d;
  logic               guard_q, guard_d, sticky_q, sticky_d;
  logic [31:0]        result_q, result_d;
  logic               out_valid_q, out_valid_d;
`ifdef FPU_MUL_FLAGS_EN
  logic [3:0]         flags_q, flags_d;
`endif

  op_class_e          cls_a, cls_b;
  logic [23:0]        mant_a, mant_b;
  logic               inc;
  logic [23:0]        rnd_sum;
  logic signed [9:0]  e_rnd;

  fpu_operand_classify u_cls_a (.op(a_q), .op_class(cls_a), .mant(mant_a));
  fpu_operand_classify u_cls_b (.op(b_q), .op_class(cls_b), .mant(mant_b));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    e_d         = e_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    man_d       = man_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef FPU_MUL_FLAGS_EN
    flags_d     = flags_q;
`endif
    // Round-to-nearest-even on the normalized mantissa.
    inc     = guard_q & (sticky_q | man_q[0]);
    rnd_sum = {1'b0, man_q} + {23'd0, inc};
    e_rnd   = e_q + (rnd_sum[23] ? 10'sd1 : 10'sd0);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = CHECK;
`ifdef FPU_MUL_FLAGS_EN
          flags_d = 4'b0000;
`endif
        end
      end
      CHECK: begin
        sign_d = a_q[31] ^ b_q[31];
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
          result_d = {a_q[31] ^ b_q[31], EXP_MAX, NAN_MANT};
          state_d  = DONE;
`ifdef FPU_MUL_FLAGS_EN
          flags_d  = 4'b1000;
`endif
        end else if (cls_a == INF || cls_b == INF) begin
          result_d = {a_q[31] ^ b_q[31], EXP_MAX, 23'd0};
          state_d  = DONE;
        end else if (cls_a == ZERO || cls_b == ZERO) begin
          result_d = {a_q[31] ^ b_q[31], 31'd0};
          state_d  = DONE;
        end else begin
          ma_d    = mant_a;
          mb_d    = mant_b;
          // Unsigned 10-bit wrap gives the signed biased-exponent sum.
          e_d     = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'(EXP_BIAS);
          prod_d  = 48'd0;
          cnt_d   = 5'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (mb_q[cnt_q]) begin
          prod_d = prod_q + ({24'd0, ma_q} << cnt_q);
        end
        if (cnt_q == 5'(MUL_ITERS - 1)) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      NORM: begin
        if (prod_q[47]) begin
          e_d      = e_q + 10'sd1;
          man_d    = prod_q[46:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
        end else begin
          man_d    = prod_q[45:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (e_rnd >= 10'sd255) begin
          result_d = {sign_q, EXP_MAX, 23'd0};
`ifdef FPU_MUL_FLAGS_EN
          flags_d  = 4'b0101;
`endif
        end else if (e_rnd <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
`ifdef FPU_MUL_FLAGS_EN
          flags_d  = 4'b0011;
`endif
        end else begin
          // On mantissa carry-out rnd_sum[22:0] is already zero.
          result_d = {sign_q, e_rnd[7:0], rnd_sum[22:0]};
`ifdef FPU_MUL_FLAGS_EN
          flags_d  = {3'b000, guard_q | sticky_q};
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE, then holds.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      e_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      man_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef FPU_MUL_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      e_q         <= e_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      man_q       <= man_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
`ifdef FPU_MUL_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
`ifdef FPU_MUL_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule
